// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 interrupt controller with prioritised maskable lines
// Define CP0_VECTOR_EN for vectored dispatch (EHBR + id << VEC_SHIFT).
module cp0_irq_ctrl #(
  parameter int          IRQ_NUM   = 8,
  parameter logic [31:0] EHBR_RST  = 32'h0000_0000,
  parameter int          VEC_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [IRQ_NUM-1:0] irq_in,
  input  logic [31:0]        ret_addr,
  output logic               ir,
  output logic [3:0]         irq_id,
  output logic               jump_en,
  output logic [31:0]        jump_addr
);

`ifdef CP0_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  localparam logic [1:0] OP_STORE   = 2'b01;
  localparam logic [1:0] OP_ERET    = 2'b10;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHBR   = 5'd15;

  logic               ie, exl;
  logic [IRQ_NUM-1:0] im, pending, prev;
  logic [3:0]         code;
  logic [31:0]        epc, ehbr;

  logic               is_store, is_eret, take;
  logic [IRQ_NUM-1:0] rise, eligible, w1c, take_clr;
  logic [3:0]         take_id;
  logic [31:0]        vec_off, target;
  logic [31:0]        status_val, cause_val, rd_val;

  assign is_store = (oper == OP_STORE);
  assign is_eret  = (oper == OP_ERET);
  assign rise     = irq_in & ~prev;
  assign eligible = pending & im;
  assign take     = ~is_store & ~is_eret & ir_en & ie & ~exl & (|eligible);

  // Scan downward so the lowest eligible index ends up winning.
  always_comb begin
    take_id = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) take_id = 4'(i);
    end
  end

  always_comb begin
    take_clr = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      take_clr[i] = take && (take_id == 4'(i));
    end
  end

  assign vec_off = {28'd0, take_id} << VEC_SHIFT;
  assign target  = VEC_EN ? (ehbr + vec_off) : ehbr;
  assign w1c     = (is_store && addr_w == REG_CAUSE) ? data_w[16 +: IRQ_NUM] : '0;

  always_comb begin
    status_val = '0;
    status_val[0] = ie;
    status_val[1] = exl;
    status_val[16 +: IRQ_NUM] = im;
    cause_val = '0;
    cause_val[3:0] = code;
    cause_val[16 +: IRQ_NUM] = pending;
  end

  always_comb begin
    rd_val = '0;
    case (addr_r)
      REG_STATUS: rd_val = status_val;
      REG_CAUSE:  rd_val = cause_val;
      REG_EPC:    rd_val = epc;
      REG_EHBR:   rd_val = ehbr;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie        <= 1'b0;
      exl       <= 1'b0;
      im        <= '0;
      pending   <= '0;
      prev      <= '0;
      code      <= '0;
      epc       <= '0;
      ehbr      <= EHBR_RST;
      data_r    <= '0;
      ir        <= 1'b0;
      irq_id    <= '0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else begin
      data_r  <= rd_val;
      prev    <= irq_in;
      // A fresh edge beats a same-cycle W1C or take clear of that bit.
      pending <= (pending & ~(w1c | take_clr)) | rise;
      ir      <= take;
      irq_id  <= take ? take_id : 4'd0;
      jump_en <= is_eret | take;
      jump_addr <= is_eret ? epc : (take ? target : 32'd0);

      if (is_eret) begin
        exl <= 1'b0;
      end else if (is_store) begin
        case (addr_w)
          REG_STATUS: begin
            ie  <= data_w[0];
            exl <= data_w[1];
            im  <= data_w[16 +: IRQ_NUM];
          end
          REG_EPC:  epc  <= data_w;
          REG_EHBR: ehbr <= {data_w[31:2], 2'b00};
          default: ;
        endcase
      end else if (take) begin
        epc  <= ret_addr;
        exl  <= 1'b1;
        code <= take_id;
      end
    end
  end

endmodule

// File: doc/cp0_irq_ctrl.md
# cp0_irq_ctrl

Parametrised coprocessor-0 interrupt controller: generalises the single-line CP0 to IRQ_NUM prioritised, individually maskable interrupt lines with architectural STATUS/CAUSE/EPC/EHBR registers and optional vectored dispatch. It sits beside the MEM stage, is accessed by MTC0/MFC0/ERET from the pipeline, and drives the forced-jump path into IF.

## Interface
- IRQ_NUM, 8: number of interrupt lines, legal 1..16.
- EHBR_RST, 32'h0000_0000: reset value of EHBR.
- VEC_SHIFT, 5: log2 byte spacing between vectors (vectored mode only).
- clk  in  1  main clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- oper  in  2  operation: 2'b00 none, 2'b01 store (MTC0), 2'b10 ERET, 2'b11 treated as none.
- addr_r  in  5  read register index.
- data_r  out  32  registered read data.
- addr_w  in  5  write register index.
- data_w  in  32  write data.
- ir_en  in  1  pipeline can accept an interrupt this cycle.
- irq_in  in  IRQ_NUM  external interrupt lines, rising-edge detected.
- ret_addr  in  32  address to save in EPC when an interrupt is taken.
- ir  out  1  one-cycle pulse: interrupt taken.
- irq_id  out  4  index of the taken line, valid while ir=1.
- jump_en  out  1  one-cycle forced-jump strobe.
- jump_addr  out  32  jump target, valid while jump_en=1, else 0.

## Operation
- Register map: 12 STATUS, 13 CAUSE, 14 EPC, 15 EHBR; other indices read 0, writes ignored.
- STATUS: [0] IE, [1] EXL, [16+:IRQ_NUM] IM; others read 0. All listed bits writable by store.
- CAUSE: [3:0] code (last taken id, read-only), [16+:IRQ_NUM] pending; store clears each pending bit written with 1 (W1C).
- EPC: 32 bits, writable. EHBR: writable, bits [1:0] forced 0.
- Edge detect: per line, prev register (reset 0); irq_in[i] & ~prev[i] at an edge sets pending[i]. Set wins over simultaneous W1C of the same bit.
- Take condition at an edge: oper==none & ir_en & IE & ~EXL & |(pending & IM). Selected id = lowest set index of pending & IM (index 0 highest priority).
- On take: ir=1, irq_id=id, jump_en=1, jump_addr=target, EPC<=ret_addr, EXL<=1, code<=id, pending[id]<=0.
- ERET (highest priority): jump_en=1, jump_addr=EPC (current value), EXL<=0; no take that cycle.
- Store: performs write; no take that cycle; jump_en=0.
- Otherwise ir=0, jump_en=0, jump_addr=0.
- EXL=1 blocks further takes (no nesting) until ERET or software clears EXL.
- data_r <= register[addr_r] every edge (value before that edge's write).

## Timing
- Reset (async assert): STATUS=0, CAUSE=0, EPC=0, EHBR=EHBR_RST, prev=0, data_r=0, ir=0, irq_id=0, jump_en=0, jump_addr=0.
- irq_in rising sampled at edge k -> pending visible after k; earliest take at edge k+1 -> ir/jump_en high during cycle k+1..k+2; 2-cycle latency.
- ERET sampled at edge k -> jump_en high for exactly the following cycle.
- ir and jump_en are always single-cycle pulses; pipeline must deassert oper the next cycle.
- Store to STATUS at edge k affects take decision from edge k+1.
- irq_in high at reset release with prev=0 counts as a rising edge at the first edge.
- Reset mid-jump: outputs drop to 0 immediately; pending lost.

## Configuration
- CP0_VECTOR_EN defined: take target = EHBR + (id << VEC_SHIFT).
- CP0_VECTOR_EN undefined: take target = EHBR for every line; handler reads CAUSE.code.

## Test plan
- Reset, EHBR<=0x100, STATUS<=IE|IM=0xFF, pulse irq_in[3] -> 2 cycles later ir=1, irq_id=3, jump_en=1, jump_addr=0x100 (0x160 with CP0_VECTOR_EN), EPC=ret_addr, EXL=1, CAUSE.code=3.
- irq_in[5] and irq_in[2] rise together -> take id 2 first; after ERET (jump_addr=EPC, EXL=0) take id 5 next eligible cycle.
- IM bit 4 cleared, irq_in[4] rises -> pending[4]=1 in CAUSE readback, no ir; set IM bit 4 -> take one cycle after the store.
- oper=ERET in the same cycle take would occur -> jump to EPC only, pending retained, take on a later edge.
- Store CAUSE with 1 in bit 16+1 while irq_in[1] rises same edge -> pending[1] stays 1; no edge -> pending[1] cleared.
- Deassert rst_n while jump_en=1 -> all outputs 0 asynchronously, STATUS=0, EHBR=EHBR_RST.
